// File: rtl/adxl345_spi_reader.sv
// adxl345_spi_reader
//   SPI master (mode 3) for the ADXL345 accelerometer. After reset it writes
//   POWER_CTL (0x2D <- 0x08, measure mode), then DATA_FORMAT (0x31 <-
//   DATA_FORMAT_VAL). After that it reads DATAX0..DATAY1 in one multibyte
//   burst every SAMPLE_PERIOD clocks and publishes X/Y as signed 16-bit words.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   spi_cs_n     chip select, active low
//   spi_sclk     SPI clock, idles high (mode 3)
//   spi_mosi     master data out; 0 when no command/data bit is driven
//   spi_miso     slave data in, sampled on the clk cycle SCLK rises
//   accel_x      signed X sample {X1,X0}
//   accel_y      signed Y sample {Y1,Y0}
//   sample_valid one-cycle pulse when accel_x/accel_y update
//   init_done    high once both configuration writes have completed
module adxl345_spi_reader #(
  parameter int          CLK_DIV         = 25,
  parameter int          SAMPLE_PERIOD   = 500000,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h08
) (
  input  logic               clk,
  input  logic               rst,
  output logic               spi_cs_n,
  output logic               spi_sclk,
  output logic               spi_mosi,
  input  logic               spi_miso,
  output logic signed [15:0] accel_x,
  output logic signed [15:0] accel_y,
  output logic               sample_valid,
  output logic               init_done
);

  localparam int CW = $clog2(2 * CLK_DIV + 1);
  localparam int PW = $clog2(SAMPLE_PERIOD + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {INIT_PWR, INIT_FMT, IDLE, READ, PUBLISH} state_t;
  typedef enum logic [2:0] {PH_READY, PH_SETUP, PH_LOW, PH_HIGH, PH_GAP} phase_t;

  state_t              state_q, state_d;
  phase_t              phase_q, phase_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [5:0]          bit_cnt_q, bit_cnt_d;
  logic [39:0]         tx_q, tx_d;
  logic [31:0]         rx_q, rx_d;
  logic [PW-1:0]       per_cnt_q, per_cnt_d;
  logic                per_run_q, per_run_d;
  logic                cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic signed [15:0]  accel_x_q, accel_x_d;
  logic signed [15:0]  accel_y_q, accel_y_d;
  logic                valid_q, valid_d;
  logic                init_done_q, init_done_d;

  logic        cnt_last;
  logic        start;
  logic        done;
  logic        wrap;
  logic [5:0]  nbits;
  logic [39:0] start_word;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    per_cnt_d   = per_cnt_q;
    per_run_d   = per_run_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    accel_x_d   = accel_x_q;
    accel_y_d   = accel_y_q;
    valid_d     = 1'b0;
    init_done_d = init_done_q;
    start       = 1'b0;
    done        = 1'b0;
    start_word  = 40'h0;
    cnt_last    = (cnt_q == HALF_LAST);
    nbits       = (state_q == READ) ? 6'd40 : 6'd16;

    // Period counter free-runs once IDLE has been reached; each wrap is one read slot.
    wrap = per_run_q && (per_cnt_q == PER_LAST);
    if (per_run_q) begin
      per_cnt_d = wrap ? '0 : per_cnt_q + 1'b1;
    end

    // Frame requests: command/data left-aligned in the 40-bit shifter.
    case (state_q)
      INIT_PWR: begin
        start      = (phase_q == PH_READY);
        start_word = {16'h2D08, 24'h0};
      end
      INIT_FMT: begin
        start      = (phase_q == PH_READY);
        start_word = {8'h31, DATA_FORMAT_VAL, 24'h0};
      end
      IDLE: begin
        if (wrap && (phase_q == PH_READY)) begin
          start      = 1'b1;
          start_word = {8'hF2, 32'h0};
          state_d    = READ;
        end
      end
      PUBLISH: state_d = IDLE;
      default: ;
    endcase

    // Bit engine: SCLK falls with new MOSI, rises CLK_DIV later with MISO capture.
    case (phase_q)
      PH_READY: begin
        if (start) begin
          cs_n_d    = 1'b0;
          tx_d      = start_word;
          bit_cnt_d = '0;
          cnt_d     = '0;
          phase_d   = PH_SETUP;
        end
      end
      PH_SETUP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          sclk_d  = 1'b0;
          mosi_d  = tx_q[39];
          tx_d    = {tx_q[38:0], 1'b0};
          phase_d = PH_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_LOW: begin
        if (cnt_last) begin
          cnt_d     = '0;
          sclk_d    = 1'b1;
          rx_d      = {rx_q[30:0], spi_miso};
          bit_cnt_d = bit_cnt_q + 1'b1;
          phase_d   = PH_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_HIGH: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_cnt_q == nbits) begin
            // Last rising edge was CLK_DIV cycles ago: release chip select.
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            done    = 1'b1;
            phase_d = PH_GAP;
          end else begin
            sclk_d  = 1'b0;
            mosi_d  = tx_q[39];
            tx_d    = {tx_q[38:0], 1'b0};
            phase_d = PH_LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PH_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          phase_d = PH_READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: phase_d = PH_READY;
    endcase

    // Frame completion advances the sequence; the last 32 MISO bits are X0,X1,Y0,Y1.
    if (done) begin
      case (state_q)
        INIT_PWR: state_d = INIT_FMT;
        INIT_FMT: begin
          state_d     = IDLE;
          init_done_d = 1'b1;
          per_run_d   = 1'b1;
          per_cnt_d   = '0;
        end
        READ: begin
          state_d   = PUBLISH;
          accel_x_d = {rx_q[23:16], rx_q[31:24]};
          accel_y_d = {rx_q[7:0], rx_q[15:8]};
          valid_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT_PWR;
      phase_q     <= PH_READY;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      per_cnt_q   <= '0;
      per_run_q   <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      accel_x_q   <= '0;
      accel_y_q   <= '0;
      valid_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      per_cnt_q   <= per_cnt_d;
      per_run_q   <= per_run_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      accel_x_q   <= accel_x_d;
      accel_y_q   <= accel_y_d;
      valid_q     <= valid_d;
      init_done_q <= init_done_d;
    end
  end

  assign spi_cs_n     = cs_n_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = mosi_q;
  assign accel_x      = accel_x_q;
  assign accel_y      = accel_y_q;
  assign sample_valid = valid_q;
  assign init_done    = init_done_q;

endmodule

// File: tb/tb_adxl345_spi_reader.sv
// Testbench for adxl345_spi_reader.
//   dut0: CLK_DIV=2, SAMPLE_PERIOD=400 with an ADXL345 slave model (reset, init,
//         read/publish, period, reset mid-read).
//   dut1: CLK_DIV=3, SAMPLE_PERIOD=300, used for SPI timing measurements.
module tb_adxl345_spi_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- dut0 ----------------
  logic               rst0, cs0, sclk0, mosi0, miso0, valid0, idone0;
  logic signed [15:0] ax0, ay0;

  adxl345_spi_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(400), .DATA_FORMAT_VAL(8'h08)) dut0 (
    .clk(clk), .rst(rst0), .spi_cs_n(cs0), .spi_sclk(sclk0), .spi_mosi(mosi0),
    .spi_miso(miso0), .accel_x(ax0), .accel_y(ay0), .sample_valid(valid0),
    .init_done(idone0));

  // ---------------- dut1 ----------------
  logic               rst1, cs1, sclk1, mosi1, miso1, valid1, idone1;
  logic signed [15:0] ax1, ay1;

  adxl345_spi_reader #(.CLK_DIV(3), .SAMPLE_PERIOD(300), .DATA_FORMAT_VAL(8'h08)) dut1 (
    .clk(clk), .rst(rst1), .spi_cs_n(cs1), .spi_sclk(sclk1), .spi_mosi(mosi1),
    .spi_miso(miso1), .accel_x(ax1), .accel_y(ay1), .sample_valid(valid1),
    .init_done(idone1));

  // ---------------- dut0 monitor + slave model ----------------
  logic [39:0] stream0 = {8'h00, 8'h34, 8'h12, 8'hCE, 8'hFF};
  logic [39:0] frm_q[$];
  int          len_q[$];
  logic        idn_q[$];
  int          csfall_q[$];
  int          vcyc_q[$];
  logic [15:0] ax_q[$];
  logic [15:0] ay_q[$];
  logic [39:0] cur_bits = '0;
  int          cur_len = 0;
  int          sidx = 0;
  int          vlong = 0;
  logic        p_cs0 = 1'b1, p_sclk0 = 1'b1, p_valid0 = 1'b0;

  always @(negedge clk) begin
    if (cs0 && !p_cs0) begin
      frm_q.push_back(cur_bits); len_q.push_back(cur_len); idn_q.push_back(idone0);
    end
    if (!cs0 && p_cs0) begin
      cur_bits = '0; cur_len = 0; sidx = 0; csfall_q.push_back(cyc);
    end
    if (!cs0 && sclk0 && !p_sclk0) begin
      cur_bits = {cur_bits[38:0], mosi0}; cur_len++;
    end
    if (!cs0 && !sclk0 && p_sclk0) begin
      if (sidx < 40) miso0 = stream0[39 - sidx];
      sidx++;
    end
    if (valid0) begin
      vcyc_q.push_back(cyc); ax_q.push_back(ax0); ay_q.push_back(ay0);
    end
    if (valid0 && p_valid0) vlong++;
    p_cs0 = cs0; p_sclk0 = sclk0; p_valid0 = valid0;
  end

  // ---------------- dut1 timing monitor ----------------
  int   f1 = 0;
  int   t_csf = 0, t_csr = 0, t_sf = 0, t_sr = 0;
  logic first_fall = 1'b0, have_rise = 1'b0;
  int   lo_n = 0, lo_bad = 0, hi_n = 0, hi_bad = 0, su_n = 0, su_bad = 0;
  int   ho_n = 0, ho_bad = 0, gap_n = 0, gap_bad = 0, mosi_bad = 0;
  logic p_cs1 = 1'b1, p_sclk1 = 1'b1, p_mosi1 = 1'b0;

  always @(negedge clk) begin
    if (!cs1 && p_cs1) begin
      t_csf = cyc; first_fall = 1'b1;
      if (have_rise) begin gap_n++; if (cyc - t_csr < 6) gap_bad++; end
    end
    if (cs1 && !p_cs1) begin
      f1++; have_rise = 1'b1; t_csr = cyc; ho_n++;
      if (cyc - t_sr != 3) ho_bad++;
    end
    if (!cs1 && !sclk1 && p_sclk1) begin
      if (first_fall) begin
        su_n++; if (cyc - t_csf != 3) su_bad++; first_fall = 1'b0;
      end else begin
        hi_n++; if (cyc - t_sr != 3) hi_bad++;
      end
      t_sf = cyc;
    end
    if (!cs1 && sclk1 && !p_sclk1) begin
      lo_n++; if (cyc - t_sf != 3) lo_bad++; t_sr = cyc;
    end
    if (!cs1 && (mosi1 !== p_mosi1) && !(!sclk1 && p_sclk1)) mosi_bad++;
    p_cs1 = cs1; p_sclk1 = sclk1; p_mosi1 = mosi1;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    int k;
    repeat (3) @(negedge clk);
    n_cmp++; if (cs0 !== 1'b1) begin n_fail++; $display("FAIL rst_cs_n: got %b want 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b1) begin n_fail++; $display("FAIL rst_sclk: got %b want 1", sclk0); end
    n_cmp++; if (mosi0 !== 1'b0) begin n_fail++; $display("FAIL rst_mosi: got %b want 0", mosi0); end
    n_cmp++; if (ax0 !== 16'h0) begin n_fail++; $display("FAIL rst_accel_x: got %h want 0000", ax0); end
    n_cmp++; if (ay0 !== 16'h0) begin n_fail++; $display("FAIL rst_accel_y: got %h want 0000", ay0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", valid0); end
    n_cmp++; if (idone0 !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b want 0", idone0); end
    rst0 = 1'b0;
    rst1 = 1'b0;
    k = 0;
    while (k < 2) begin
      @(posedge clk); #1; k++;
      if (cs0 === 1'b0) break;
    end
    n_cmp++; if (cs0 !== 1'b0) begin n_fail++; $display("FAIL rst_release_cs_fall: got %b want 0 within 2 cycles", cs0); end
  endtask

  task automatic test_init();
    int k = 0;
    while (frm_q.size() < 2 && k < 600) begin @(posedge clk); k++; end
    n_cmp++;
    if (frm_q.size() < 2) begin n_fail++; $display("FAIL init_timeout: got %0d frames want 2", frm_q.size()); return; end
    n_cmp++; if (frm_q[0][15:0] !== 16'h2D08) begin n_fail++; $display("FAIL init_pwr_frame: got %h want 2d08", frm_q[0][15:0]); end
    n_cmp++; if (len_q[0] != 16) begin n_fail++; $display("FAIL init_pwr_len: got %0d want 16", len_q[0]); end
    n_cmp++; if (frm_q[1][15:0] !== 16'h3108) begin n_fail++; $display("FAIL init_fmt_frame: got %h want 3108", frm_q[1][15:0]); end
    n_cmp++; if (len_q[1] != 16) begin n_fail++; $display("FAIL init_fmt_len: got %0d want 16", len_q[1]); end
    n_cmp++; if (idn_q[0] !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %b want 0", idn_q[0]); end
    n_cmp++; if (idn_q[1] !== 1'b1) begin n_fail++; $display("FAIL init_done_at_cs_rise: got %b want 1", idn_q[1]); end
  endtask

  task automatic test_read();
    int k = 0;
    while (vcyc_q.size() < 1 && k < 1000) begin @(posedge clk); k++; end
    n_cmp++;
    if (vcyc_q.size() < 1 || frm_q.size() < 3) begin n_fail++; $display("FAIL read_timeout: got %0d samples want 1", vcyc_q.size()); return; end
    n_cmp++; if (frm_q[2][39:32] !== 8'hF2) begin n_fail++; $display("FAIL read_cmd: got %h want f2", frm_q[2][39:32]); end
    n_cmp++; if (frm_q[2][31:0] !== 32'h0) begin n_fail++; $display("FAIL read_mosi_idle: got %h want 00000000", frm_q[2][31:0]); end
    n_cmp++; if (len_q[2] != 40) begin n_fail++; $display("FAIL read_len: got %0d want 40", len_q[2]); end
    n_cmp++; if (ax_q[0] !== 16'h1234) begin n_fail++; $display("FAIL read_accel_x: got %h want 1234", ax_q[0]); end
    n_cmp++; if (ay_q[0] !== 16'hFFCE) begin n_fail++; $display("FAIL read_accel_y: got %h want ffce", ay_q[0]); end
    @(negedge clk);
    n_cmp++; if ($signed(ay0) != -50) begin n_fail++; $display("FAIL read_accel_y_signed: got %0d want -50", $signed(ay0)); end
    n_cmp++; if (ax0 !== 16'h1234) begin n_fail++; $display("FAIL read_hold_x: got %h want 1234", ax0); end
    n_cmp++; if (vlong != 0) begin n_fail++; $display("FAIL read_valid_width: got %0d extra cycles want 0", vlong); end
  endtask

  task automatic test_period();
    int k = 0;
    while (vcyc_q.size() < 3 && k < 2000) begin @(posedge clk); k++; end
    n_cmp++;
    if (vcyc_q.size() < 3 || csfall_q.size() < 5) begin n_fail++; $display("FAIL period_timeout: got %0d samples want 3", vcyc_q.size()); return; end
    n_cmp++; if (csfall_q[3] - csfall_q[2] != 400) begin n_fail++; $display("FAIL period_cs_1: got %0d want 400", csfall_q[3] - csfall_q[2]); end
    n_cmp++; if (csfall_q[4] - csfall_q[3] != 400) begin n_fail++; $display("FAIL period_cs_2: got %0d want 400", csfall_q[4] - csfall_q[3]); end
    n_cmp++; if (vcyc_q[1] - vcyc_q[0] != 400) begin n_fail++; $display("FAIL period_valid_1: got %0d want 400", vcyc_q[1] - vcyc_q[0]); end
    n_cmp++; if (vcyc_q[2] - vcyc_q[1] != 400) begin n_fail++; $display("FAIL period_valid_2: got %0d want 400", vcyc_q[2] - vcyc_q[1]); end
  endtask

  task automatic test_timing();
    int k = 0;
    while (f1 < 4 && k < 2000) begin @(posedge clk); k++; end
    n_cmp++;
    if (f1 < 4) begin n_fail++; $display("FAIL timing_timeout: got %0d frames want 4", f1); return; end
    n_cmp++; if (lo_n == 0 || lo_bad != 0) begin n_fail++; $display("FAIL timing_sclk_low: got %0d bad of %0d want 0 bad", lo_bad, lo_n); end
    n_cmp++; if (hi_n == 0 || hi_bad != 0) begin n_fail++; $display("FAIL timing_sclk_high: got %0d bad of %0d want 0 bad", hi_bad, hi_n); end
    n_cmp++; if (su_n == 0 || su_bad != 0) begin n_fail++; $display("FAIL timing_cs_to_fall: got %0d bad of %0d want 0 bad", su_bad, su_n); end
    n_cmp++; if (ho_n == 0 || ho_bad != 0) begin n_fail++; $display("FAIL timing_rise_to_cs: got %0d bad of %0d want 0 bad", ho_bad, ho_n); end
    n_cmp++; if (gap_n == 0 || gap_bad != 0) begin n_fail++; $display("FAIL timing_cs_gap: got %0d bad of %0d want 0 bad", gap_bad, gap_n); end
    n_cmp++; if (mosi_bad != 0) begin n_fail++; $display("FAIL timing_mosi_edge: got %0d changes off falling edge want 0", mosi_bad); end
    n_cmp++; if (idone1 !== 1'b1) begin n_fail++; $display("FAIL timing_init_done: got %b want 1", idone1); end
  endtask

  task automatic test_reset_mid_read();
    int k = 0;
    int nf;
    while (!(cs0 === 1'b0 && cur_len == 20 && frm_q.size() >= 5) && k < 1500) begin @(posedge clk); k++; end
    n_cmp++;
    if (!(cs0 === 1'b0 && cur_len == 20)) begin n_fail++; $display("FAIL midrd_timeout: got %0d bits want 20", cur_len); return; end
    #3;
    rst0 = 1'b1;
    #1;
    n_cmp++; if (cs0 !== 1'b1) begin n_fail++; $display("FAIL midrd_cs_n: got %b want 1", cs0); end
    n_cmp++; if (sclk0 !== 1'b1) begin n_fail++; $display("FAIL midrd_sclk: got %b want 1", sclk0); end
    n_cmp++; if (ax0 !== 16'h0) begin n_fail++; $display("FAIL midrd_accel_x: got %h want 0000", ax0); end
    n_cmp++; if (ay0 !== 16'h0) begin n_fail++; $display("FAIL midrd_accel_y: got %h want 0000", ay0); end
    n_cmp++; if (idone0 !== 1'b0) begin n_fail++; $display("FAIL midrd_init_done: got %b want 0", idone0); end
    repeat (2) @(negedge clk);
    nf = frm_q.size();
    rst0 = 1'b0;
    k = 0;
    while (frm_q.size() <= nf && k < 300) begin @(posedge clk); k++; end
    n_cmp++;
    if (frm_q.size() <= nf) begin n_fail++; $display("FAIL midrd_restart_timeout: got %0d frames want %0d", frm_q.size(), nf + 1); return; end
    n_cmp++; if (frm_q[nf][15:0] !== 16'h2D08) begin n_fail++; $display("FAIL midrd_restart_frame: got %h want 2d08", frm_q[nf][15:0]); end
    n_cmp++; if (len_q[nf] != 16) begin n_fail++; $display("FAIL midrd_restart_len: got %0d want 16", len_q[nf]); end
  endtask

  initial begin
    rst0  = 1'b1;
    rst1  = 1'b1;
    miso0 = 1'b0;
    miso1 = 1'b1;
    test_reset();
    test_init();
    test_read();
    test_period();
    test_timing();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adxl345_spi_reader.md
Name: adxl345_spi_reader

Overview:
SPI master that configures the on-board ADXL345 accelerometer and periodically reads X/Y acceleration. It publishes the samples as signed 16-bit words with a one-cycle valid strobe. It is the producing end of the accel_x/accel_y interface consumed by the tilt-to-LED mapping logic.

Parameters:
CLK_DIV, 25, clk cycles per SCLK half-period (50 MHz clk gives 1 MHz SCLK); legal range 2 or more.
SAMPLE_PERIOD, 500000, clk cycles between read starts (100 Hz at 50 MHz); legal range 100*CLK_DIV or more.
DATA_FORMAT_VAL, 8'h08, byte written to DATA_FORMAT (0x31); 0x08 is full-resolution ±2 g, 4-wire.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
spi_cs_n  out  1  chip select, active low
spi_sclk  out  1  SPI clock, mode 3 (idles high)
spi_mosi  out  1  master data out
spi_miso  in  1  slave data in
accel_x  out  16  signed X sample, two's complement
accel_y  out  16  signed Y sample, two's complement
sample_valid  out  1  one-cycle pulse when accel_x/accel_y update
init_done  out  1  high once both configuration writes have completed

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: spi_cs_n=1, spi_sclk=1, spi_mosi=0, accel_x=0, accel_y=0, sample_valid=0, init_done=0, FSM=INIT_PWR, all counters 0.
- Reset mid-operation: reset forces the reset values immediately (asynchronous). The transaction is abandoned; after release the block restarts at INIT_PWR.
- Transaction engine:
  - Drive spi_cs_n low, then wait CLK_DIV cycles.
  - For each bit, MSB first:
    - spi_sclk falls and spi_mosi takes the next bit in the same cycle.
    - spi_sclk rises CLK_DIV cycles later.
    - spi_miso is sampled in the clk cycle in which spi_sclk rises.
    - Each bit lasts 2*CLK_DIV cycles.
  - After the last rising edge, hold spi_cs_n low for CLK_DIV cycles, then raise it.
  - spi_cs_n stays high for at least 2*CLK_DIV cycles before the next transaction.
- spi_mosi is 0 whenever no command/data bit is being driven, including during read data bytes.
- FSM states: INIT_PWR -> INIT_FMT -> IDLE -> READ -> PUBLISH -> IDLE.
  - INIT_PWR: 16-bit write, bytes 0x2D then 0x08 (measure mode).
  - INIT_FMT: 16-bit write, bytes 0x31 then DATA_FORMAT_VAL. init_done rises in the cycle spi_cs_n returns high, and stays high until reset.
  - IDLE: waits for the period counter to reach SAMPLE_PERIOD-1.
  - READ: 40-bit transaction, command byte 0xF2 (read | multibyte | 0x32), then four bytes captured in order X0, X1, Y0, Y1.
  - PUBLISH: one cycle. accel_x={X1,X0} and accel_y={Y1,Y0} update, and sample_valid=1 in this cycle only.
- Period counter:
  - Free-runs from the first entry into IDLE.
  - Wraps to 0 on reaching SAMPLE_PERIOD-1.
  - Each wrap starts one READ, so reads begin exactly SAMPLE_PERIOD cycles apart.
  - A wrap that occurs while not in IDLE is not possible under the parameter range, and is not required to queue.
- accel_x/accel_y hold their value between PUBLISH cycles. Partially received bytes never appear on the outputs.
- Byte assembly: the low byte arrives first, and the 16-bit result is taken as-is with no sign extension or shifting.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs at reset values in the same cycle. After release, spi_cs_n falls within 2 cycles.
- Init: CLK_DIV=2, decode MOSI on SCLK rising edges -> frames 0x2D,0x08 then 0x31,0x08, each exactly 16 SCLK pulses. init_done=1 after the second frame's spi_cs_n rises.
- Read/publish: slave model returns 0x34,0x12,0xCE,0xFF -> command 0xF2 seen, accel_x=16'h1234, accel_y=16'hFFCE (-50), sample_valid high for exactly 1 cycle.
- Period: SAMPLE_PERIOD=400, CLK_DIV=2 -> successive spi_cs_n falling edges for reads exactly 400 cycles apart. Three consecutive sample_valid pulses are 400 cycles apart.
- Timing: CLK_DIV=3 -> SCLK high and low phases each 3 cycles, MOSI changes only on SCLK falling edges, CS-to-first-fall 3 cycles, CS gap of 6 cycles or more.
- Reset mid-READ: assert rst after 20 bits of a read -> spi_cs_n=1 immediately, accel_x/accel_y=0, and the next transaction after release is the 0x2D write.
